// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 grid display driver.
// New grids land in a shadow buffer and are copied to the display buffer only at a
// frame boundary, so a frame never shows two different grids. Per-capture statistics
// (population, extinct, stable, generation count) are registered alongside.
module grid_scan_driver #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic [6:0]  population,
  output logic        stable,
  output logic        extinct,
  output logic [15:0] gen_count
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DwellMax = DW'(SCAN_DIV - 1);

  logic [63:0]   r_shadow;
  logic [63:0]   r_display;
  logic          r_pending;
  logic [2:0]    r_row;
  logic [DW-1:0] r_dwell;
  logic [6:0]    r_population;
  logic          r_stable;
  logic          r_extinct;
  logic [15:0]   r_gen_count;

  logic          w_dwell_last;
  logic          w_boundary;
  logic [6:0]    w_popcount;
  logic          w_same;

  assign w_dwell_last = (r_dwell == DwellMax);
  assign w_boundary   = w_dwell_last && (r_row == 3'd7);
  // The shadow always holds the most recent capture, so it doubles as the
  // "previous grid" reference; gen_count != 0 says such a capture exists.
  assign w_same       = (r_gen_count != 16'd0) && (grid == r_shadow);

  // Count live cells of the incoming grid.
  always_comb begin
    w_popcount = 7'd0;
    for (int i = 0; i < 64; i++) begin
      w_popcount = w_popcount + {6'd0, grid[i]};
    end
  end

  // Outputs decoded straight from registered scan state and display buffer.
  assign row_sel    = 8'h01 << r_row;
  assign col_data   = r_display[{r_row, 3'b000} +: 8];
  assign frame_done = w_boundary;
  assign population = r_population;
  assign stable     = r_stable;
  assign extinct    = r_extinct;
  assign gen_count  = r_gen_count;

  // Scan counters: dwell SCAN_DIV cycles on each row, rows wrap 7 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= 3'd0;
      r_dwell <= '0;
    end else if (w_dwell_last) begin
      r_dwell <= '0;
      r_row   <= r_row + 3'd1;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Shadow/display double buffer; display only changes at a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= 64'd0;
      r_display <= 64'd0;
      r_pending <= 1'b0;
    end else begin
      // Uses the old shadow, so a grid arriving on the boundary waits a frame.
      if (w_boundary && r_pending) begin
        r_display <= r_shadow;
      end
      if (grid_valid) begin
        r_shadow  <= grid;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Per-capture statistics, held between captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_population <= 7'd0;
      r_extinct    <= 1'b1;
      r_stable     <= 1'b0;
      r_gen_count  <= 16'd0;
    end else if (grid_valid) begin
      r_population <= w_popcount;
      r_extinct    <= (grid == 64'd0);
      r_stable     <= w_same;
      if (r_gen_count != 16'hFFFF) begin
        r_gen_count <= r_gen_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Bench for grid_scan_driver: per-cycle reference model check, a vector table for the
// capture statistics, and directed sequences for frame-boundary and reset corners.
module tb_grid_scan_driver;

  localparam int unsigned D     = 4;
  localparam int unsigned FRAME = 8 * D;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic [6:0]  population;
  logic        stable;
  logic        extinct;
  logic [15:0] gen_count;

  grid_scan_driver #(.SCAN_DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .grid      (grid),
    .grid_valid(grid_valid),
    .row_sel   (row_sel),
    .col_data  (col_data),
    .frame_done(frame_done),
    .population(population),
    .stable    (stable),
    .extinct   (extinct),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time since reset drives the scan position arithmetically.
  int unsigned m_t       = 0;
  logic [63:0] m_latest  = 64'd0;  // newest grid not yet shown
  bit          m_waiting = 1'b0;   // a newer grid awaits the next boundary
  logic [63:0] m_shown   = 64'd0;
  logic [63:0] m_last    = 64'd0;
  bit          m_have    = 1'b0;
  logic [6:0]  m_pop     = 7'd0;
  bit          m_ext     = 1'b1;
  bit          m_stable  = 1'b0;
  int unsigned m_gen     = 0;

  typedef struct {
    logic [63:0] grid;
    bit          gv;
    logic [6:0]  pop;
    bit          ext;
    bit          st;
    logic [15:0] gen;
  } vec_t;

  vec_t vecs[8];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, m_t, act, exp);
    end
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_t = 0; m_latest = 64'd0; m_waiting = 1'b0; m_shown = 64'd0;
      m_have = 1'b0; m_pop = 7'd0; m_ext = 1'b1; m_stable = 1'b0; m_gen = 0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_waiting) begin
        m_shown   = m_latest;
        m_waiting = 1'b0;
      end
      if (grid_valid) begin
        m_stable  = m_have && (grid == m_last);
        m_last    = grid;
        m_have    = 1'b1;
        m_latest  = grid;
        m_waiting = 1'b1;
        m_pop     = 7'($countones(grid));
        m_ext     = (grid == 64'd0);
        if (m_gen < 65535) m_gen++;
      end
      m_t++;
    end
  endtask

  task automatic check_outputs();
    int unsigned row;
    logic [7:0] exp_sel;
    row     = (m_t / D) % 8;
    exp_sel = 8'h01 << row;
    check("row_sel", 64'(row_sel), 64'(exp_sel));
    check("col_data", 64'(col_data), 64'(m_shown[row*8 +: 8]));
    check("frame_done", 64'(frame_done), 64'((m_t % FRAME) == FRAME - 1));
    check("population", 64'(population), 64'(m_pop));
    check("extinct", 64'(extinct), 64'(m_ext));
    check("stable", 64'(stable), 64'(m_stable));
    check("gen_count", 64'(gen_count), 64'(m_gen));
  endtask

  // Inputs change only at negedge; the model steps at the posedge that samples them.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_t(int unsigned n);
    while (m_t < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int fdc;
    int changes;
    logic [7:0] prev;
    logic [63:0] hgrid;
    logic [63:0] prev_grid;

    vecs[0] = '{64'h0412_6424_0034_3C28, 1'b1, 7'd17, 1'b0, 1'b0, 16'd1};
    vecs[1] = '{64'h0412_6424_0034_3C28, 1'b1, 7'd17, 1'b0, 1'b1, 16'd2};
    vecs[2] = '{64'h0,                   1'b1, 7'd0,  1'b1, 1'b0, 16'd3};
    vecs[3] = '{64'h0,                   1'b1, 7'd0,  1'b1, 1'b1, 16'd4};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd64, 1'b0, 1'b0, 16'd5};
    vecs[5] = '{64'h0,                   1'b0, 7'd64, 1'b0, 1'b0, 16'd5};
    vecs[6] = '{64'h1,                   1'b1, 7'd1,  1'b0, 1'b0, 16'd6};
    vecs[7] = '{64'h8000_0000_0000_0001, 1'b1, 7'd2,  1'b0, 1'b0, 16'd7};

    grid       = 64'hFFFF_FFFF_FFFF_FFFF;
    grid_valid = 1'b1;
    reset      = 1'b1;

    // Reset held 3 cycles with grid_valid high: captures must be ignored.
    repeat (3) step();
    reset      = 1'b0;
    grid_valid = 1'b0;
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_row_sel", 64'(row_sel), 64'h01);
    check("rst_col", 64'(col_data), 64'h00);
    check("rst_extinct", 64'(extinct), 64'd1);
    check("rst_pop", 64'(population), 64'd0);

    // Single capture, then shown after the first frame boundary.
    grid       = 64'h0412_6424_0034_3C28;
    grid_valid = 1'b1;
    step();
    grid_valid = 1'b0;
    check("cap_pop", 64'(population), 64'd17);
    check("cap_extinct", 64'(extinct), 64'd0);
    check("cap_gen", 64'(gen_count), 64'd1);
    wait_t(31);
    check("cap_not_yet", 64'(col_data), 64'h00);
    wait_t(32);
    check("cap_row0_sel", 64'(row_sel), 64'h01);
    check("cap_row0", 64'(col_data), 64'h28);
    wait_t(36);
    check("cap_row1", 64'(col_data), 64'h3C);
    wait_t(60);
    check("cap_row7", 64'(col_data), 64'h04);

    // Free-running scan cadence over two frames.
    wait_t(64);
    fdc     = 0;
    changes = 0;
    prev    = row_sel;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_done) fdc++;
      if (row_sel != prev) changes++;
      prev = row_sel;
    end
    check("fd_per_2frames", 64'(fdc), 64'd2);
    check("row_changes", 64'(changes), 64'd16);

    // Capture statistics table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      grid       = vecs[i].grid;
      grid_valid = vecs[i].gv;
      step();
      grid_valid = 1'b0;
      check($sformatf("vec%0d_pop", i), 64'(population), 64'(vecs[i].pop));
      check($sformatf("vec%0d_ext", i), 64'(extinct), 64'(vecs[i].ext));
      check($sformatf("vec%0d_stable", i), 64'(stable), 64'(vecs[i].st));
      check($sformatf("vec%0d_gen", i), 64'(gen_count), 64'(vecs[i].gen));
    end

    // Grid arriving on the boundary cycle with nothing pending waits a full frame.
    do_reset();
    hgrid = 64'hA5A5_0F0F_1234_5678;
    wait_t(31);
    check("bnd_fd", 64'(frame_done), 64'd1);
    grid       = hgrid;
    grid_valid = 1'b1;
    step();
    grid_valid = 1'b0;
    check("bnd_row0_old", 64'(col_data), 64'h00);
    wait_t(60);
    check("bnd_row7_old", 64'(col_data), 64'h00);
    wait_t(64);
    check("bnd_row0_new", 64'(col_data), 64'h78);

    // Reset mid-frame while row 3 is driven.
    wait_t(76);
    check("mid_row_sel", 64'(row_sel), 64'h08);
    do_reset();
    check("mid_rst_sel", 64'(row_sel), 64'h01);
    check("mid_rst_col", 64'(col_data), 64'h00);
    check("mid_rst_gen", 64'(gen_count), 64'd0);

    // Randomized traffic with repeats, zero grids and occasional resets.
    prev_grid = 64'd0;
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      grid_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       grid = 64'd0;
        1:       grid = prev_grid;
        default: grid = {$urandom, $urandom};
      endcase
      prev_grid = grid;
      step();
    end
    reset      = 1'b0;
    grid_valid = 1'b0;

    // Saturation of the generation counter.
    do_reset();
    grid_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      grid = {$urandom, $urandom};
      step();
    end
    grid_valid = 1'b0;
    check("gen_saturated", 64'(gen_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_scan_driver.md
GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

Interface
REQ-001 The block SHALL have one parameter: SCAN_DIV, default 4, the number of clock cycles each row is driven (legal range 1..256).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port grid, input, 64 bits: the cell grid; row r = grid[8r+7:8r], column c = bit c of that byte; 1 = live.
REQ-005 Port grid_valid, input, 1 bit: high for one cycle when grid holds a new generation.
REQ-006 Port row_sel, output, 8 bits: one-hot active-high row enable.
REQ-007 Port col_data, output, 8 bits: the column pattern for the selected row.
REQ-008 Port frame_done, output, 1 bit: one-cycle pulse marking the last cycle of a full 8-row frame.
REQ-009 Port population, output, 7 bits: number of live cells (0..64) in the last captured grid.
REQ-010 Port stable, output, 1 bit: the last two captured grids are identical.
REQ-011 Port extinct, output, 1 bit: the last captured grid is all zero.
REQ-012 Port gen_count, output, 16 bits: number of grids captured since reset.

Function
REQ-013 Shadow buffer: on a rising edge with grid_valid=1, the block SHALL load grid into a 64-bit shadow buffer and set a pending flag.
REQ-014 Scan state: row counter 0..7 and dwell counter 0..SCAN_DIV-1; dwell SHALL increment every cycle; at SCAN_DIV-1 it SHALL wrap to 0 and the row SHALL advance; row 7 SHALL wrap to row 0.
REQ-015 row_sel SHALL equal 1<<row and col_data SHALL equal display[8*row+7:8*row], both decoded from registered state with no cycle skipped between rows.
REQ-016 frame_done SHALL be high exactly when row=7 and dwell=SCAN_DIV-1, i.e. one cycle every 8*SCAN_DIV cycles.
REQ-017 Frame boundary (frame_done cycle): if pending was set before that cycle, display SHALL load from shadow at that edge and pending SHALL clear; display SHALL never change at any other time, so there is no tearing.
REQ-018 grid_valid coinciding with a frame boundary: the display SHALL take the previously held shadow only if pending was already set; the new grid SHALL go to shadow, pending SHALL end up 1, and the new grid SHALL show after the next boundary.
REQ-019 Back-to-back grid_valid within one frame: the later grid SHALL overwrite the shadow, and only the latest grid SHALL be displayed.
REQ-020 population SHALL be the registered popcount of the captured grid, valid the cycle after grid_valid (latency 1).
REQ-021 extinct SHALL be registered (grid==0) on each capture, with latency 1.
REQ-022 stable SHALL be set on a capture whose grid equals the previously captured grid and at least one prior capture exists since reset; it SHALL be cleared on any differing capture.
REQ-023 gen_count SHALL increment by 1 per grid_valid and saturate at 16'hFFFF.
REQ-024 population, extinct, stable and gen_count SHALL hold their values between captures.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set: shadow and display = 0, pending = 0, row = 0, dwell = 0, row_sel = 8'h01, col_data = 8'h00, frame_done = 0, population = 0, extinct = 1, stable = 0, gen_count = 0.
REQ-026 reset SHALL dominate grid_valid; a grid_valid during reset SHALL be ignored.
REQ-027 Reset mid-frame SHALL restart scanning at row 0, dwell 0 on the cycle after the reset edge.

Verification (SCAN_DIV=4)
REQ-028 Hold reset 3 cycles with grid_valid=1 -> after release: gen_count=0, row_sel=8'h01, col_data=8'h00, extinct=1, population=0.
REQ-029 Single grid_valid with grid=64'h0412_6424_0034_3C28 -> next cycle: population=17, extinct=0, gen_count=1; after the next frame_done: row 0 col_data=8'h28, row 1=8'h3C, row 7=8'h04.
REQ-030 Free-run scan -> row_sel steps 01,02,04,...,80,01 with each value held 4 cycles; frame_done high 1 cycle in every 32.
REQ-031 Same grid captured twice, then 64'h0 -> stable=1 after the second capture; after the third capture stable=0, extinct=1, population=0.
REQ-032 grid_valid asserted in the frame_done cycle with no pending grid -> display unchanged for the following frame; new grid appears after the next frame_done.
REQ-033 Assert reset while row_sel=8'h08 -> next cycle row_sel=8'h01, col_data=8'h00, gen_count=0.
